// File: rtl/hdmi_tx_cfg_seq.sv
// Walks a ROM table of 3-byte I2C writes onto the HDMI transmitter (open-drain master), re-run on hot-plug.
// Entry takes 2 fetch cycles + 116 ticks of CLK_DIV clocks; no clock stretching, a NACK aborts the walk after STOP.
module hdmi_tx_cfg_seq #(
    parameter int CLK_DIV     = 250,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_ENTRIES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  hdmi_intn,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [23:0]           cfg_data,
    output logic                  scl_t,
    output logic                  sda_t,
    input  logic                  sda_i,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_index
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_START, S_BIT, S_STOP, S_NEXT, S_FINISH, S_ERROR
    } state_t;

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_WIDTH:0] IDX_LAST = (ADDR_WIDTH + 1)'(NUM_ENTRIES);

    state_t                state, state_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic                  bus_phase;
    logic [1:0]            qtr;
    logic [4:0]            slot;
    logic [26:0]           shreg;
    logic                  nack;
    logic [ADDR_WIDTH:0]   index;
    logic                  fetch_wait;
    logic                  pending;
    logic [2:0]            intn_sync;
    logic                  trig;
    logic                  req;
    logic                  ack_slot;
    logic                  slot_end;

    assign trig      = intn_sync[2] & ~intn_sync[1];
    assign req       = start | trig;
    assign bus_phase = (state == S_START) || (state == S_BIT) || (state == S_STOP);
    assign tick      = bus_phase && (div_cnt == DIV_LAST);
    assign slot_end  = tick && (qtr == 2'd3);
    assign ack_slot  = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
    assign cfg_addr  = index[ADDR_WIDTH-1:0];

    // Divider restarts with every START so each entry's bus phase is exactly 116 ticks.
    always_ff @(posedge clk) begin
        if (rst || !bus_phase || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req || pending) state_nxt = S_FETCH;
            S_FETCH: begin
                if (fetch_wait) begin
                    if (index == IDX_LAST || cfg_data[23:16] == 8'hFF) state_nxt = S_FINISH;
                    else                                               state_nxt = S_START;
                end
            end
            S_START:  if (slot_end) state_nxt = S_BIT;
            S_BIT:    if (slot_end && slot == 5'd26) state_nxt = S_STOP;
            S_STOP:   if (slot_end) state_nxt = nack ? S_ERROR : S_NEXT;
            S_NEXT:   state_nxt = S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            S_ERROR:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_t      <= 1'b1;
            sda_t      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
            pending    <= 1'b0;
            index      <= '0;
            fetch_wait <= 1'b0;
            qtr        <= '0;
            slot       <= '0;
            shreg      <= '1;
            nack       <= 1'b0;
            intn_sync  <= '1;
        end else begin
            intn_sync <= {intn_sync[1:0], hdmi_intn};
            if (req && state != S_IDLE) pending <= 1'b1;
            if (tick) qtr <= qtr + 2'd1;
            case (state)
                S_IDLE: begin
                    if (req || pending) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        pending    <= 1'b0;
                        index      <= '0;
                        fetch_wait <= 1'b0;
                    end
                end
                S_FETCH: begin
                    fetch_wait <= 1'b1;
                    if (fetch_wait) begin
                        // Ack positions carry 1 so the shifter releases SDA for the slave.
                        shreg <= {cfg_data[23:16], 1'b1, cfg_data[15:8], 1'b1, cfg_data[7:0], 1'b1};
                        qtr   <= '0;
                        slot  <= '0;
                        nack  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        case (qtr)
                            2'd0:    begin scl_t <= 1'b1; sda_t <= 1'b1; end
                            2'd2:    sda_t <= 1'b0;
                            2'd3:    scl_t <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        case (qtr)
                            2'd0:    sda_t <= shreg[26];
                            2'd1:    scl_t <= 1'b1;
                            2'd2:    if (ack_slot) nack <= nack | sda_i;
                            default: begin
                                scl_t <= 1'b0;
                                shreg <= {shreg[25:0], 1'b1};
                                slot  <= slot + 5'd1;
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        case (qtr)
                            2'd0:    sda_t <= 1'b0;
                            2'd1:    scl_t <= 1'b1;
                            2'd3:    sda_t <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_NEXT: begin
                    index      <= index + (ADDR_WIDTH + 1)'(1);
                    fetch_wait <= 1'b0;
                end
                S_FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                S_ERROR: begin
                    busy      <= 1'b0;
                    error     <= 1'b1;
                    err_index <= index[ADDR_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
